// File: rtl/fft64_reorder.sv
// Ping-pong reorder buffer for a 64-point FFT: converts bit-reversed output order to natural order.
// Each frame is read out as a 64-cycle burst that starts on the edge that stores its last sample.
module fft64_reorder #(
    parameter int DW     = 10,
    parameter int BITREV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din_re,
    input  logic [DW-1:0] din_im,
    input  logic          din_valid,
    output logic [DW-1:0] dout_re,
    output logic [DW-1:0] dout_im,
    output logic          dout_valid,
    output logic [5:0]    dout_index,
    output logic          dout_last,
    output logic [7:0]    frame_cnt
);

    typedef enum logic {IDLE, READ} state_t;

    state_t          state_reg, state_next;
    logic [5:0]      n_reg;
    logic            wr_bank_reg;
    logic [5:0]      k_reg, k_next;
    logic            rd_bank_reg, rd_bank_next;
    logic [5:0]      n_rev;
    logic [5:0]      wr_addr;
    logic            handoff;
    logic            rd_en;
    logic [6:0]      rd_addr;
    logic [2*DW-1:0] mem [128];
    logic [2*DW-1:0] rd_data_reg;
    logic            valid_reg;
    logic [5:0]      index_reg;
    logic            last_reg;
    logic [7:0]      frame_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_rev
            assign n_rev[gi] = n_reg[5-gi];
        end
        if (BITREV != 0) begin : g_bitrev
            assign wr_addr = n_rev;
        end else begin : g_linear
            assign wr_addr = n_reg;
        end
    endgenerate

    assign handoff = din_valid && (n_reg == 6'd63);

    // Write side: sample counter and bank select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg       <= 6'd0;
            wr_bank_reg <= 1'b0;
        end else if (din_valid) begin
            n_reg <= n_reg + 6'd1;
            if (n_reg == 6'd63)
                wr_bank_reg <= ~wr_bank_reg;
        end
    end

    // Banks live in one array addressed by {bank, entry}; contents are never reset.
    always_ff @(posedge clk) begin
        if (din_valid)
            mem[{wr_bank_reg, wr_addr}] <= {din_re, din_im};
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            k_reg       <= 6'd0;
            rd_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

    // Entry 0 is issued on the handoff edge itself, so k holds the next entry to read.
    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        rd_bank_next = rd_bank_reg;
        if (handoff) begin
            state_next   = READ;
            k_next       = 6'd1;
            rd_bank_next = wr_bank_reg;
        end else if (state_reg == READ) begin
            k_next = k_reg + 6'd1;
            if (k_reg == 6'd63)
                state_next = IDLE;
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {rd_bank_reg, k_reg};
        if (handoff) begin
            rd_en   = 1'b1;
            rd_addr = {wr_bank_reg, 6'd0};
        end else if (state_reg == READ) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            index_reg     <= 6'd0;
            last_reg      <= 1'b0;
            frame_cnt_reg <= 8'd0;
        end else begin
            valid_reg <= rd_en;
            index_reg <= rd_en ? rd_addr[5:0] : 6'd0;
            last_reg  <= rd_en && (rd_addr[5:0] == 6'd63);
            if (rd_en && (rd_addr[5:0] == 6'd63))
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    // Gate data with valid so stale or never-written bank contents cannot leak out.
    assign dout_re    = valid_reg ? rd_data_reg[2*DW-1:DW] : '0;
    assign dout_im    = valid_reg ? rd_data_reg[DW-1:0]    : '0;
    assign dout_valid = valid_reg;
    assign dout_index = index_reg;
    assign dout_last  = last_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_fft64_reorder.sv
// Checks both reorder modes against a frame-level model: each completed input frame
// schedules 64 natural-order outputs that must appear back-to-back from the next sample point.
module tb_fft64_reorder;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din_re = '0, din_im = '0;
    logic          din_valid = 1'b0;

    logic [DW-1:0] o1_re, o1_im, o0_re, o0_im;
    logic          o1_valid, o1_last, o0_valid, o0_last;
    logic [5:0]    o1_index, o0_index;
    logic [7:0]    o1_fc, o0_fc;

    always #5 clk = ~clk;

    fft64_reorder #(.DW(DW), .BITREV(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
        .dout_re(o1_re), .dout_im(o1_im), .dout_valid(o1_valid), .dout_index(o1_index),
        .dout_last(o1_last), .frame_cnt(o1_fc));

    fft64_reorder #(.DW(DW), .BITREV(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
        .dout_re(o0_re), .dout_im(o0_im), .dout_valid(o0_valid), .dout_index(o0_index),
        .dout_last(o0_last), .frame_cnt(o0_fc));

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [5:0]    idx;
        logic          last;
    } exp_t;

    typedef struct {
        int frames;
        int gap;     // 0 contiguous, 1 alternate valid/idle, 2 random idles
        int data;    // 0 re=n, 1 re=n+64f, 2 random
        int exp_fc;
    } scen_t;

    exp_t          q1[$], q0[$];
    logic [DW-1:0] fr_re[64], fr_im[64];
    int            fill = 0;
    int            fc1 = 0, fc0 = 0;
    int            checks = 0, passed = 0;

    function automatic int brev(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < 6; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic compare_outputs();
        exp_t e;
        logic [63:0] req;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            if (e.last) fc1 = (fc1 + 1) % 256;
            req = {28'd0, 1'b1, e.idx, e.last, e.re, e.im, fc1[7:0]};
        end else begin
            req = {28'd0, 1'b0, 6'd0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, fc1[7:0]};
        end
        check("bitrev_out", {28'd0, o1_valid, o1_index, o1_last, o1_re, o1_im, o1_fc}, req);
        if (q0.size() > 0) begin
            e = q0.pop_front();
            if (e.last) fc0 = (fc0 + 1) % 256;
            req = {28'd0, 1'b1, e.idx, e.last, e.re, e.im, fc0[7:0]};
        end else begin
            req = {28'd0, 1'b0, 6'd0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, fc0[7:0]};
        end
        check("linear_out", {28'd0, o0_valid, o0_index, o0_last, o0_re, o0_im, o0_fc}, req);
    endtask

    task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        exp_t e;
        din_valid = v;
        din_re    = re;
        din_im    = im;
        @(posedge clk);
        #1;
        if (v) begin
            fr_re[fill] = re;
            fr_im[fill] = im;
            fill++;
            if (fill == 64) begin
                for (int k = 0; k < 64; k++) begin
                    e.idx  = 6'(k);
                    e.last = (k == 63);
                    e.re   = fr_re[brev(k)];
                    e.im   = fr_im[brev(k)];
                    q1.push_back(e);
                    e.re   = fr_re[k];
                    e.im   = fr_im[k];
                    q0.push_back(e);
                end
                fill = 0;
            end
        end
        compare_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        q1.delete();
        q0.delete();
        fill = 0;
        fc1 = 0;
        fc0 = 0;
        compare_outputs();
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int f, input int gap, input int data);
        logic [DW-1:0] re, im;
        for (int n = 0; n < 64; n++) begin
            case (data)
                0:       begin re = DW'(n);          im = DW'(63 - n); end
                1:       begin re = DW'(n + 64 * f); im = DW'(63 - n); end
                default: begin re = DW'($urandom);   im = DW'($urandom); end
            endcase
            step(1'b1, re, im);
            if (gap == 1) idle(1);
            else if (gap == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
    endtask

    scen_t tbl[5];

    initial begin
        tbl[0] = '{frames: 1,   gap: 0, data: 0, exp_fc: 1};
        tbl[1] = '{frames: 1,   gap: 1, data: 0, exp_fc: 1};
        tbl[2] = '{frames: 3,   gap: 0, data: 1, exp_fc: 3};
        tbl[3] = '{frames: 4,   gap: 2, data: 2, exp_fc: 4};
        tbl[4] = '{frames: 256, gap: 0, data: 2, exp_fc: 0};

        for (int s = 0; s < 5; s++) begin
            reset_dut();
            idle(3);
            for (int f = 0; f < tbl[s].frames; f++)
                send_frame(f, tbl[s].gap, tbl[s].data);
            idle(70);
            check($sformatf("frame_cnt_scen%0d_rev", s), 64'(o1_fc), 64'(tbl[s].exp_fc));
            check($sformatf("frame_cnt_scen%0d_lin", s), 64'(o0_fc), 64'(tbl[s].exp_fc));
        end

        // Reset after 30 samples: the partial frame must be discarded.
        reset_dut();
        for (int n = 0; n < 30; n++) step(1'b1, DW'(500 + n), DW'(n));
        reset_dut();
        send_frame(0, 0, 0);
        idle(70);
        check("frame_cnt_after_midreset", 64'(o1_fc), 64'd1);

        // Reset while a frame is being read out: the burst must stop at once.
        send_frame(0, 0, 2);
        idle(20);
        reset_dut();
        idle(50);
        check("frame_cnt_after_readreset", 64'(o1_fc), 64'd0);
        check("valid_after_readreset", 64'(o1_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
